// File: rtl/mxint8_pkg.sv
// Shared definitions for the MXINT8 <-> FP32 datapath.
//   - element / scale / FP32 widths and the implicit element fraction bits
//   - special encodings (E8M0 NaN scale, canonical FP32 quiet NaN)
//   - default block size and the unpacker state enum
//   - lead_one_pos(): index of the most significant set bit of a magnitude
package mxint8_pkg;

  localparam int MXINT8_ELEM_WIDTH  = 8;
  localparam int E8M0_WIDTH         = 8;
  localparam int FP32_WIDTH         = 32;
  localparam int FRAC_BITS          = 6;   // element value = int8 / 2^FRAC_BITS
  localparam int DEFAULT_BLOCK_SIZE = 32;

  localparam logic [E8M0_WIDTH-1:0] E8M0_NAN  = 8'hFF;
  localparam logic [FP32_WIDTH-1:0] FP32_QNAN = 32'h7FC00000;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Position of the leading one; 0 for an all-zero input (callers
  // special-case zero before using the result).
  function automatic logic [2:0] lead_one_pos(input logic [MXINT8_ELEM_WIDTH-1:0] m);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < MXINT8_ELEM_WIDTH; i++) begin
      if (m[i]) p = 3'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/mxint8_elem_to_fp32.sv
// Combinational conversion of one MXINT8 element plus its shared E8M0 scale
// into an exact IEEE-754 binary32 value.
//   scale_i : E8M0 scale X, value 2^(X-127); 8'hFF means NaN
//   elem_i  : two's-complement int8 with 6 implicit fraction bits
//   fp32_o  : FP32 encoding of elem/64 * 2^(X-127)
// Every int8 * power-of-two fits in 8 significant bits, so no rounding is
// ever needed: the only cases are NaN, zero, normal, subnormal and the single
// overflow pattern (X=254, e=-128) that lands on infinity.
module mxint8_elem_to_fp32
  import mxint8_pkg::*;
(
  input  logic [E8M0_WIDTH-1:0]        scale_i,
  input  logic [MXINT8_ELEM_WIDTH-1:0] elem_i,
  output logic [FP32_WIDTH-1:0]        fp32_o
);

  logic                         sign;
  logic [MXINT8_ELEM_WIDTH-1:0] mag;
  logic [2:0]                   p;
  logic signed [9:0]            exp_s;
  logic [22:0]                  frac_n;
  logic [22:0]                  frac_s;
  logic [4:0]                   sub_amt;

  always_comb begin
    sign    = elem_i[MXINT8_ELEM_WIDTH-1];
    // -128 negates to 8'h80, which read unsigned is the wanted magnitude 128.
    mag     = sign ? 8'(-elem_i) : elem_i;
    p       = lead_one_pos(mag);
    exp_s   = $signed({2'b00, scale_i}) + $signed({7'b0, p}) - 10'(FRAC_BITS);
    // Shift the leading one to bit 23 so it falls off; what remains is the
    // left-aligned fraction.
    frac_n  = 23'(mag) << (5'd23 - {2'b00, p});
    // Subnormal path is only taken for X <= 6-p, so X+16 <= 22 and the low
    // five bits of X carry the whole shift.
    sub_amt = scale_i[4:0] + 5'd16;
    frac_s  = 23'(mag) << sub_amt;

    fp32_o = '0;
    if (scale_i == E8M0_NAN) begin
      fp32_o = FP32_QNAN;
    end else if (mag == '0) begin
      fp32_o = '0;  // never a negative zero
    end else if (exp_s >= 10'sd255) begin
      fp32_o = {sign, 8'hFF, 23'h0};
    end else if (exp_s >= 10'sd1) begin
      fp32_o = {sign, exp_s[7:0], frac_n};
    end else begin
      fp32_o = {sign, 8'h00, frac_s};
    end
  end

endmodule

// File: rtl/mxint8_fp32_unpack.sv
// MXINT8 block -> FP32 scalar stream.
// Accepts one block (shared E8M0 scale + BLOCK_SIZE int8 elements) on a
// valid/ready input, then emits BLOCK_SIZE FP32 scalars, one per cycle, on a
// valid/ready output with element index and last flag.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : block handshake; in_scale = E8M0, in_elems = packed int8s
//   out_valid/out_ready : scalar handshake
//   out_data            : FP32 value of element out_idx (0 when idle)
//   out_idx, out_last   : element index, high on element BLOCK_SIZE-1
// in_ready rises combinationally on the last output handshake so a waiting
// block is taken with no bubble between blocks.
module mxint8_fp32_unpack
  import mxint8_pkg::*;
#(
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [E8M0_WIDTH-1:0]                   in_scale,
  input  logic [BLOCK_SIZE*MXINT8_ELEM_WIDTH-1:0] in_elems,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [FP32_WIDTH-1:0]                   out_data,
  output logic [$clog2(BLOCK_SIZE)-1:0]           out_idx,
  output logic                                    out_last
);

  localparam int                IDX_W    = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  state_e                                          state_q, state_d;
  logic [IDX_W-1:0]                                idx_q, idx_d;
  logic [E8M0_WIDTH-1:0]                           scale_q, scale_d;
  logic [BLOCK_SIZE-1:0][MXINT8_ELEM_WIDTH-1:0]    elems_q, elems_d;

  logic                         out_hs;
  logic                         accept;
  logic [MXINT8_ELEM_WIDTH-1:0] elem_cur;
  logic [FP32_WIDTH-1:0]        conv;

  // Control: FSM next state, index counter, block latch enables.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scale_d   = scale_q;
    elems_d   = elems_q;

    out_valid = (state_q == STREAM);
    out_last  = out_valid && (idx_q == LAST_IDX);
    out_hs    = out_valid && out_ready;
    in_ready  = (state_q == IDLE) || (out_hs && out_last);
    accept    = in_valid && in_ready;

    if (accept) begin
      state_d = STREAM;
      idx_d   = '0;
      scale_d = in_scale;
      elems_d = in_elems;
    end else if (out_hs) begin
      if (out_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Block payload needs no reset: it is only observed while in STREAM.
  always_ff @(posedge clk) begin
    scale_q <= scale_d;
    elems_q <= elems_d;
  end

  assign elem_cur = elems_q[idx_q];

  mxint8_elem_to_fp32 u_conv (
    .scale_i (scale_q),
    .elem_i  (elem_cur),
    .fp32_o  (conv)
  );

  assign out_data = out_valid ? conv : '0;
  assign out_idx  = idx_q;

endmodule

// File: tb/tb_mxint8_fp32_unpack.sv
module tb_mxint8_fp32_unpack;
  localparam int BS = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [7:0]      in_scale = '0;
  logic [BS*8-1:0] in_elems = '0;
  logic            in_ready, out_valid, out_last;
  logic [31:0]     out_data;
  logic [4:0]      out_idx;

  int checks = 0;
  int errors = 0;

  logic [BS-1:0][7:0] el;
  logic [31:0]        exp_tab [0:4];
  int                 n_tab;
  logic [31:0]        fill;

  always #5 clk = ~clk;

  mxint8_fp32_unpack #(.BLOCK_SIZE(BS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_scale  (in_scale),
    .in_elems  (in_elems),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"},   32'(in_ready),  32'd1);
    chk({tag, "_data"},  out_data,       32'd0);
    chk({tag, "_idx"},   32'(out_idx),   32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
  endtask

  task automatic send(input string tag, input logic [7:0] x, input logic [BS-1:0][7:0] e);
    in_scale = x;
    in_elems = e;
    in_valid = 1'b1;
    chk({tag, "_in_rdy"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  // Walks one full block: beats below n_tab expect exp_tab, the rest expect fill.
  task automatic stream(input string tag);
    logic [31:0] e;
    for (int i = 0; i < BS; i++) begin
      e = (i < n_tab) ? exp_tab[i] : fill;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_idx"},   32'(out_idx),   32'(i));
      chk({tag, "_last"},  32'(out_last),  32'(i == BS - 1));
      chk({tag, "_data"},  out_data,       e);
      tick;
    end
    check_idle({tag, "_end"});
  endtask

  initial begin
    tick;
    tick;
    check_idle("reset");
    rst = 1'b0;
    tick;
    check_idle("post_reset");

    // X=127 basic values
    el = '0;
    el[0] = 8'h40; el[1] = 8'hC0; el[2] = 8'h01; el[3] = 8'h00; el[4] = 8'h7F;
    exp_tab[0] = 32'h3F800000; exp_tab[1] = 32'hBF800000; exp_tab[2] = 32'h3C800000;
    exp_tab[3] = 32'h00000000; exp_tab[4] = 32'h3FFE0000;
    n_tab = 5; fill = 32'h0;
    send("x127", 8'd127, el);
    stream("x127");

    // NaN scale with random elements
    for (int i = 0; i < BS; i++) el[i] = 8'($urandom);
    n_tab = 0; fill = 32'h7FC00000;
    send("nan", 8'hFF, el);
    stream("nan");

    // X=254: overflow to -inf and largest normal
    el = '0; el[0] = 8'h80; el[1] = 8'h7F;
    exp_tab[0] = 32'hFF800000; exp_tab[1] = 32'h7F7E0000;
    n_tab = 2; fill = 32'h0;
    send("x254", 8'd254, el);
    stream("x254");

    // X=0: subnormal outputs
    el = '0; el[0] = 8'h01; el[1] = 8'hFF;
    exp_tab[0] = 32'h00010000; exp_tab[1] = 32'h80010000;
    n_tab = 2; fill = 32'h0;
    send("x0", 8'd0, el);
    stream("x0");

    // Back-to-back blocks with in_valid held high
    for (int i = 0; i < BS; i++) el[i] = 8'h40;
    in_scale = 8'd127; in_elems = el; in_valid = 1'b1;
    tick;
    for (int i = 0; i < BS; i++) el[i] = 8'hC0;
    in_elems = el;  // second block waits; must not disturb the first
    for (int b = 0; b < 2 * BS; b++) begin
      if (b == BS) in_valid = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_idx",   32'(out_idx),   32'(b % BS));
      chk("b2b_last",  32'(out_last),  32'((b % BS) == BS - 1));
      chk("b2b_rdy",   32'(in_ready),  32'((b % BS) == BS - 1));
      chk("b2b_data",  out_data,       (b < BS) ? 32'h3F800000 : 32'hBF800000);
      tick;
    end
    check_idle("b2b_end");

    // Backpressure at idx 7, then reset mid-block at idx 10
    for (int i = 0; i < BS; i++) el[i] = 8'h01;
    el[7] = 8'h40; el[8] = 8'hC0;
    send("bp", 8'd127, el);
    for (int i = 0; i < 7; i++) tick;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_elems = {8{32'($urandom)}};
      chk("bp_idx",   32'(out_idx),   32'd7);
      chk("bp_data",  out_data,       32'h3F800000);
      chk("bp_last",  32'(out_last),  32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rdy",   32'(in_ready),  32'd0);
      tick;
    end
    chk("bp_hold_idx", 32'(out_idx), 32'd7);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_resume_idx",  32'(out_idx), 32'd8);
    chk("bp_resume_data", out_data,     32'hBF800000);
    tick;
    tick;
    chk("rst_pre_idx",  32'(out_idx), 32'd10);
    chk("rst_pre_data", out_data,     32'h3C800000);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("mid_rst");

    el = '0; el[0] = 8'h01;
    exp_tab[0] = 32'h3C800000;
    n_tab = 1; fill = 32'h0;
    send("after_rst", 8'd127, el);
    stream("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
